// File: rtl/hc_pkg.sv
// Shared Huffman front-end definitions: FSM encoding, sort direction codes and the
// compare-and-swap key also used by the code-construction stage.
package hc_pkg;

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SORT  = 2'd2,
    ST_EMIT  = 2'd3
  } hc_state_e;

  localparam logic SORT_ASC  = 1'b0;
  localparam logic SORT_DESC = 1'b1;

  localparam int KEY_CNT_W = 32;
  localparam int KEY_IDX_W = 16;

  // True when entry a must move behind entry b; equal counts keep the smaller symbol first.
  function automatic logic key_swap(input logic [KEY_CNT_W-1:0] cnt_a,
                                    input logic [KEY_IDX_W-1:0] idx_a,
                                    input logic [KEY_CNT_W-1:0] cnt_b,
                                    input logic [KEY_IDX_W-1:0] idx_b,
                                    input logic                 desc);
    logic swap;
    if (cnt_a == cnt_b)        swap = (idx_a > idx_b);
    else if (desc == SORT_DESC) swap = (cnt_a < cnt_b);
    else                        swap = (cnt_a > cnt_b);
    return swap;
  endfunction

endpackage

// File: rtl/rank_sort_core.sv
// Odd-even transposition sorter over (count, symbol) pairs: one pass per step, N_SYM passes.
// Exposes the post-pass array so the caller can capture the final pass without an extra cycle.
module rank_sort_core
  import hc_pkg::*;
#(
  parameter int N_SYM = 6,
  parameter int CNT_W = 8,
  parameter int IDX_W = 3
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   load_i,
  input  logic                   step_i,
  input  logic                   desc_i,
  input  logic [N_SYM*CNT_W-1:0] cnt_i,
  output logic                   done_o,
  output logic [N_SYM*CNT_W-1:0] cnt_nxt_o,
  output logic [N_SYM*IDX_W-1:0] idx_nxt_o
);

  localparam int PASS_W = $clog2(N_SYM);

  logic [CNT_W-1:0]  cnt_q [N_SYM];
  logic [CNT_W-1:0]  cnt_d [N_SYM];
  logic [IDX_W-1:0]  idx_q [N_SYM];
  logic [IDX_W-1:0]  idx_d [N_SYM];
  logic [PASS_W-1:0] pass_q;
  logic              phase_q;

  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    for (int j = 0; j < N_SYM - 1; j++) begin
      if (((j % 2) == 1) == phase_q &&
          key_swap(KEY_CNT_W'(cnt_q[j]), KEY_IDX_W'(idx_q[j]),
                   KEY_CNT_W'(cnt_q[j+1]), KEY_IDX_W'(idx_q[j+1]), desc_i)) begin
        cnt_d[j]   = cnt_q[j+1];
        cnt_d[j+1] = cnt_q[j];
        idx_d[j]   = idx_q[j+1];
        idx_d[j+1] = idx_q[j];
      end
    end
  end

  assign done_o = step_i && (pass_q == PASS_W'(N_SYM - 1));

  for (genvar k = 0; k < N_SYM; k++) begin : g_flat
    assign cnt_nxt_o[k*CNT_W +: CNT_W] = cnt_d[k];
    assign idx_nxt_o[k*IDX_W +: IDX_W] = idx_d[k];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pass_q  <= '0;
      phase_q <= 1'b0;
      for (int k = 0; k < N_SYM; k++) begin
        cnt_q[k] <= '0;
        idx_q[k] <= '0;
      end
    end else if (load_i) begin
      pass_q  <= '0;
      phase_q <= 1'b0;
      for (int k = 0; k < N_SYM; k++) begin
        cnt_q[k] <= cnt_i[k*CNT_W +: CNT_W];
        idx_q[k] <= IDX_W'(k + 1);
      end
    end else if (step_i) begin
      pass_q  <= done_o ? '0 : pass_q + PASS_W'(1);
      phase_q <= ~phase_q;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: rtl/symbol_rank_sorter.sv
// Framed symbol histogram with saturating counters, followed by a stable rank sort of the
// final counts. Input stalls (in_ready low) from the in_last handshake until the ranking is emitted.
module symbol_rank_sorter
  import hc_pkg::*;
#(
  parameter  int N_SYM  = 6,
  parameter  int DATA_W = 8,
  parameter  int CNT_W  = 8,
  localparam int IDX_W  = $clog2(N_SYM + 1)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  input  logic [DATA_W-1:0]      in_data,
  input  logic                   in_last,
  output logic                   in_ready,
  input  logic                   desc,
  output logic                   cnt_valid,
  output logic [N_SYM*CNT_W-1:0] cnt_out,
  output logic                   sort_valid,
  output logic [N_SYM*IDX_W-1:0] sort_idx,
  output logic [N_SYM*CNT_W-1:0] sort_cnt,
  output logic                   busy
);

  localparam int CMP_W = DATA_W + 32;

  hc_state_e              state_q;
  logic                   in_ready_q;
  logic                   desc_q;
  logic                   cnt_valid_q;
  logic                   sort_valid_q;
  logic [N_SYM*CNT_W-1:0] cnt_out_q;
  logic [N_SYM*IDX_W-1:0] sort_idx_q;
  logic [N_SYM*CNT_W-1:0] sort_cnt_q;
  logic [CNT_W-1:0]       hist_q [N_SYM];
  logic [CNT_W-1:0]       hist_d [N_SYM];
  logic [N_SYM*CNT_W-1:0] hist_flat;

  logic                   accept;
  logic                   sort_done;
  logic [N_SYM*CNT_W-1:0] core_cnt;
  logic [N_SYM*IDX_W-1:0] core_idx;

  assign accept = in_valid && in_ready_q;

  // Out-of-range symbols never match any counter, so they are accepted but dropped.
  always_comb begin
    hist_d = hist_q;
    for (int k = 0; k < N_SYM; k++) begin
      if (accept && (CMP_W'(in_data) == CMP_W'(k + 1)) && (hist_q[k] != '1)) begin
        hist_d[k] = hist_q[k] + CNT_W'(1);
      end
    end
  end

  for (genvar k = 0; k < N_SYM; k++) begin : g_hist_flat
    assign hist_flat[k*CNT_W +: CNT_W] = hist_d[k];
  end

  rank_sort_core #(
    .N_SYM (N_SYM),
    .CNT_W (CNT_W),
    .IDX_W (IDX_W)
  ) u_core (
    .clk       (clk),
    .reset_n   (reset_n),
    .load_i    (state_q == ST_LOAD),
    .step_i    (state_q == ST_SORT),
    .desc_i    (desc_q),
    .cnt_i     (cnt_out_q),
    .done_o    (sort_done),
    .cnt_nxt_o (core_cnt),
    .idx_nxt_o (core_idx)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_ACCUM;
      in_ready_q   <= 1'b1;
      desc_q       <= SORT_ASC;
      cnt_valid_q  <= 1'b0;
      sort_valid_q <= 1'b0;
      cnt_out_q    <= '0;
      sort_idx_q   <= '0;
      sort_cnt_q   <= '0;
      for (int k = 0; k < N_SYM; k++) hist_q[k] <= '0;
    end else begin
      cnt_valid_q  <= 1'b0;
      sort_valid_q <= 1'b0;
      case (state_q)
        ST_ACCUM: begin
          if (accept) begin
            if (in_last) begin
              cnt_out_q   <= hist_flat;
              cnt_valid_q <= 1'b1;
              desc_q      <= desc;
              in_ready_q  <= 1'b0;
              state_q     <= ST_LOAD;
              for (int k = 0; k < N_SYM; k++) hist_q[k] <= '0;
            end else begin
              hist_q <= hist_d;
            end
          end
        end
        ST_LOAD: state_q <= ST_SORT;
        // Capture the last pass's result directly so the ranking is valid in EMIT.
        ST_SORT: begin
          if (sort_done) begin
            sort_idx_q   <= core_idx;
            sort_cnt_q   <= core_cnt;
            sort_valid_q <= 1'b1;
            state_q      <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          in_ready_q <= 1'b1;
          state_q    <= ST_ACCUM;
        end
        default: state_q <= ST_ACCUM;
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign busy       = !in_ready_q;
  assign cnt_valid  = cnt_valid_q;
  assign cnt_out    = cnt_out_q;
  assign sort_valid = sort_valid_q;
  assign sort_idx   = sort_idx_q;
  assign sort_cnt   = sort_cnt_q;

endmodule

// File: tb/tb_symbol_rank_sorter.sv
// Three configurations (defaults, CNT_W=4, N_SYM=8) checked against a selection-sort reference.
module tb_symbol_rank_sorter;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [2:0] in_valid, in_last, desc;
  logic [7:0] in_data [3];
  logic [2:0] in_ready, busy, cnt_valid, sort_valid;

  logic [47:0] cnt_out0; logic [17:0] sidx0; logic [47:0] scnt0;
  logic [23:0] cnt_out1; logic [17:0] sidx1; logic [23:0] scnt1;
  logic [63:0] cnt_out2; logic [31:0] sidx2; logic [63:0] scnt2;

  symbol_rank_sorter u0 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid[0]), .in_data(in_data[0]),
    .in_last(in_last[0]), .in_ready(in_ready[0]), .desc(desc[0]), .cnt_valid(cnt_valid[0]),
    .cnt_out(cnt_out0), .sort_valid(sort_valid[0]), .sort_idx(sidx0), .sort_cnt(scnt0),
    .busy(busy[0]));

  symbol_rank_sorter #(.CNT_W(4)) u1 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid[1]), .in_data(in_data[1]),
    .in_last(in_last[1]), .in_ready(in_ready[1]), .desc(desc[1]), .cnt_valid(cnt_valid[1]),
    .cnt_out(cnt_out1), .sort_valid(sort_valid[1]), .sort_idx(sidx1), .sort_cnt(scnt1),
    .busy(busy[1]));

  symbol_rank_sorter #(.N_SYM(8)) u2 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid[2]), .in_data(in_data[2]),
    .in_last(in_last[2]), .in_ready(in_ready[2]), .desc(desc[2]), .cnt_valid(cnt_valid[2]),
    .cnt_out(cnt_out2), .sort_valid(sort_valid[2]), .sort_idx(sidx2), .sort_cnt(scnt2),
    .busy(busy[2]));

  int nsym_of [3] = '{6, 6, 8};
  int cntw_of [3] = '{8, 4, 8};
  int checks   = 0;
  int failures = 0;
  int exp_cnt [8];
  int exp_idx [8];
  int exp_scnt[8];

  task automatic chk(input string tag, input int obs, input int exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  function automatic int get_cnt(input int sel, input int k);
    case (sel)
      0:       return int'(cnt_out0[k*8 +: 8]);
      1:       return int'(cnt_out1[k*4 +: 4]);
      default: return int'(cnt_out2[k*8 +: 8]);
    endcase
  endfunction

  function automatic int get_idx(input int sel, input int k);
    case (sel)
      0:       return int'(sidx0[k*3 +: 3]);
      1:       return int'(sidx1[k*3 +: 3]);
      default: return int'(sidx2[k*4 +: 4]);
    endcase
  endfunction

  function automatic int get_scnt(input int sel, input int k);
    case (sel)
      0:       return int'(scnt0[k*8 +: 8]);
      1:       return int'(scnt1[k*4 +: 4]);
      default: return int'(scnt2[k*8 +: 8]);
    endcase
  endfunction

  function automatic int outputs_nonzero(input int sel);
    case (sel)
      0:       return int'((cnt_out0 != 0) || (sidx0 != 0) || (scnt0 != 0));
      1:       return int'((cnt_out1 != 0) || (sidx1 != 0) || (scnt1 != 0));
      default: return int'((cnt_out2 != 0) || (sidx2 != 0) || (scnt2 != 0));
    endcase
  endfunction

  // Reference: histogram with saturation, then repeatedly pick the best remaining symbol.
  task automatic model(input int sel, input int vals[$], input bit d);
    int n, maxc, best;
    bit used [8];
    n    = nsym_of[sel];
    maxc = (1 << cntw_of[sel]) - 1;
    for (int k = 0; k < 8; k++) begin
      exp_cnt[k] = 0; exp_idx[k] = 0; exp_scnt[k] = 0; used[k] = 1'b0;
    end
    foreach (vals[i])
      if (vals[i] >= 1 && vals[i] <= n && exp_cnt[vals[i]-1] < maxc) exp_cnt[vals[i]-1]++;
    for (int r = 0; r < n; r++) begin
      best = -1;
      for (int s = 0; s < n; s++) begin
        if (!used[s]) begin
          if (best < 0) best = s;
          else if (d ? (exp_cnt[s] > exp_cnt[best]) : (exp_cnt[s] < exp_cnt[best])) best = s;
        end
      end
      used[best]  = 1'b1;
      exp_idx[r]  = best + 1;
      exp_scnt[r] = exp_cnt[best];
    end
  endtask

  task automatic check_idle(input int sel, input string tag);
    chk($sformatf("%s_s%0d_in_ready", tag, sel), int'(in_ready[sel]), 1);
    chk($sformatf("%s_s%0d_busy", tag, sel), int'(busy[sel]), 0);
    chk($sformatf("%s_s%0d_cnt_valid", tag, sel), int'(cnt_valid[sel]), 0);
    chk($sformatf("%s_s%0d_sort_valid", tag, sel), int'(sort_valid[sel]), 0);
    chk($sformatf("%s_s%0d_outputs_zero", tag, sel), outputs_nonzero(sel), 0);
  endtask

  // Sends one frame, then checks pulse timing and results. abort>0 resets that many cycles
  // after the in_last handshake instead and checks that nothing is emitted.
  task automatic run_frame(input int sel, input int vals[$], input bit d, input bit hold_busy,
                           input int gap_pct, input int abort);
    int n, t, i, guard, cv, sv, rd, ncv, nsv;
    bit last;
    n = nsym_of[sel];
    model(sel, vals, d);
    i = 0; guard = 0; t = -100;
    while (i < vals.size()) begin
      @(posedge clk); #1;
      guard++;
      if (guard > 2000) begin
        chk($sformatf("s%0d_send_timeout", sel), 0, 1);
        in_valid[sel] = 1'b0;
        return;
      end
      if (int'($urandom_range(99)) < gap_pct) begin
        in_valid[sel] = 1'b0;
        desc[sel]     = 1'($urandom_range(1));
      end else begin
        last          = (i == vals.size() - 1);
        in_valid[sel] = 1'b1;
        in_data[sel]  = 8'(vals[i]);
        in_last[sel]  = last;
        desc[sel]     = last ? d : 1'($urandom_range(1));
        @(negedge clk);
        if (in_ready[sel]) begin
          if (last) t = cyc;
          i++;
        end
      end
    end
    @(posedge clk); #1;
    if (hold_busy) begin
      in_valid[sel] = 1'b1; in_data[sel] = 8'd6; in_last[sel] = 1'b1;
    end else begin
      in_valid[sel] = 1'b0;
    end
    if (abort > 0) begin
      repeat (abort - 1) @(negedge clk);
      reset_n = 1'b0;
      #1;
      check_idle(sel, "abort");
      @(negedge clk);
      reset_n = 1'b1;
      ncv = 0; nsv = 0;
      repeat (20) begin
        @(negedge clk);
        ncv += int'(cnt_valid[sel]);
        nsv += int'(sort_valid[sel]);
      end
      chk($sformatf("abort_s%0d_no_cnt_valid", sel), ncv, 0);
      chk($sformatf("abort_s%0d_no_sort_valid", sel), nsv, 0);
      chk($sformatf("abort_s%0d_outputs_zero", sel), outputs_nonzero(sel), 0);
      return;
    end
    cv = -1; sv = -1; rd = -1; nsv = 0;
    for (int c = 0; c < 40 && rd < 0; c++) begin
      @(negedge clk);
      if (cnt_valid[sel] && cv < 0) cv = cyc;
      if (sort_valid[sel]) begin
        nsv++;
        if (sv < 0) sv = cyc;
      end
      if (in_ready[sel]) begin
        rd = cyc;
        in_valid[sel] = 1'b0;
      end
      chk($sformatf("s%0d_busy_vs_ready", sel), int'(busy[sel]), int'(!in_ready[sel]));
    end
    chk($sformatf("s%0d_cnt_valid_cycle", sel), cv, t + 1);
    chk($sformatf("s%0d_sort_valid_cycle", sel), sv, t + n + 2);
    chk($sformatf("s%0d_ready_cycle", sel), rd, t + n + 3);
    chk($sformatf("s%0d_sort_valid_pulses", sel), nsv, 1);
    for (int k = 0; k < n; k++) begin
      chk($sformatf("s%0d_cnt_out[%0d]", sel, k), get_cnt(sel, k), exp_cnt[k]);
      chk($sformatf("s%0d_sort_idx[%0d]", sel, k), get_idx(sel, k), exp_idx[k]);
      chk($sformatf("s%0d_sort_cnt[%0d]", sel, k), get_scnt(sel, k), exp_scnt[k]);
    end
  endtask

  initial begin
    int q[$];
    int tmp, j, len, sel;
    int ref_asc  [6] = '{4, 2, 6, 5, 1, 3};
    int ref_desc [6] = '{1, 3, 5, 2, 6, 4};
    int ref_cntw [6] = '{1, 3, 4, 5, 6, 2};

    reset_n  = 1'b0;
    in_valid = '0; in_last = '0; desc = '0;
    for (int s = 0; s < 3; s++) in_data[s] = '0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) check_idle(s, "reset");
    reset_n = 1'b1;
    @(negedge clk);
    for (int s = 0; s < 3; s++) check_idle(s, "post_reset");

    // Counts 3,1,3,0,2,1 in shuffled order.
    q = '{1, 1, 1, 2, 3, 3, 3, 5, 5, 6};
    for (int i = q.size() - 1; i > 0; i--) begin
      j = int'($urandom_range(i)); tmp = q[i]; q[i] = q[j]; q[j] = tmp;
    end
    run_frame(0, q, 1'b0, 1'b0, 0, 0);
    for (int k = 0; k < 6; k++) chk($sformatf("plan_asc_idx[%0d]", k), get_idx(0, k), ref_asc[k]);
    run_frame(0, q, 1'b1, 1'b0, 30, 0);
    for (int k = 0; k < 6; k++) chk($sformatf("plan_desc_idx[%0d]", k), get_idx(0, k), ref_desc[k]);

    // Saturation at 15 with out-of-range values.
    q.delete();
    for (int i = 0; i < 20; i++) q.push_back(2);
    q.push_back(0); q.push_back(7); q.push_back(0); q.push_back(7);
    run_frame(1, q, 1'b0, 1'b0, 20, 0);
    for (int k = 0; k < 6; k++) chk($sformatf("plan_sat_idx[%0d]", k), get_idx(1, k), ref_cntw[k]);

    // Single beat with the producer pushing during busy; the following frame must not see it.
    q = '{6};
    run_frame(0, q, 1'b0, 1'b1, 0, 0);
    q = '{2, 4, 4, 1};
    run_frame(0, q, 1'b1, 1'b0, 0, 0);

    // All counts equal: identity ranking in both directions.
    q.delete();
    for (int i = 0; i < 16; i++) q.push_back((i % 8) + 1);
    run_frame(2, q, 1'b0, 1'b0, 10, 0);
    for (int k = 0; k < 8; k++) chk($sformatf("eq_asc_idx[%0d]", k), get_idx(2, k), k + 1);
    run_frame(2, q, 1'b1, 1'b0, 10, 0);
    for (int k = 0; k < 8; k++) chk($sformatf("eq_desc_idx[%0d]", k), get_idx(2, k), k + 1);

    // Random frames across all configurations.
    for (int f = 0; f < 9; f++) begin
      sel = f % 3;
      len = int'($urandom_range(1, 40));
      q.delete();
      for (int i = 0; i < len; i++)
        q.push_back(($urandom_range(3) == 0) ? int'($urandom_range(0, 10))
                                             : int'($urandom_range(1, 2)));
      run_frame(sel, q, 1'($urandom_range(1)), 1'b0, 25, 0);
    end

    // Reset in the middle of SORT, then a clean frame.
    q = '{3, 3, 5, 1, 1, 1};
    run_frame(0, q, 1'b0, 1'b0, 0, 4);
    q = '{5, 5, 5, 4, 6, 6};
    run_frame(0, q, 1'b1, 1'b0, 15, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
